// File: rtl/pkg_vending.sv
// pkg_vending: shared types and constants for the vending machine change path.
// Holds the sequencer state encoding, the ejector item codes, the denomination
// values and the code-to-value helper used by the sequencer and ejector models.
package pkg_vending;

    // Sequencer states; ERRO is reachable only when the ack timeout is built in.
    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        EJETA        = 3'd1,
        ESPERA_BAIXO = 3'd2,
        CONCLUI      = 3'd3,
        ERRO         = 3'd4
    } estado_t;

    // Item codes presented on ejetar_valor.
    localparam logic [1:0] ITEM_R1  = 2'b00;
    localparam logic [1:0] ITEM_R2  = 2'b01;
    localparam logic [1:0] ITEM_R5  = 2'b10;
    localparam logic [1:0] ITEM_R10 = 2'b11;

    // Denomination values in reais.
    localparam int unsigned VALOR_R1  = 1;
    localparam int unsigned VALOR_R2  = 2;
    localparam int unsigned VALOR_R5  = 5;
    localparam int unsigned VALOR_R10 = 10;

    // Value in reais of one dispensed item.
    function automatic logic [3:0] valor_item(input logic [1:0] codigo);
        logic [3:0] valor;
        case (codigo)
            ITEM_R1:  valor = 4'(VALOR_R1);
            ITEM_R2:  valor = 4'(VALOR_R2);
            ITEM_R5:  valor = 4'(VALOR_R5);
            default:  valor = 4'(VALOR_R10);
        endcase
        return valor;
    endfunction

endpackage

// File: rtl/controle_devolucao_detector_borda.sv
// detector_borda: registered rising-edge detector for the return request.
// subida_o is combinational: current level high while the registered copy is low.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic sinal_i,
    output logic subida_o
);

    logic anterior_q;

    // Registered copy of the input level from the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anterior_q <= 1'b0;
        end else begin
            anterior_q <= sinal_i;
        end
    end

    assign subida_o = sinal_i & ~anterior_q;

endmodule

// File: rtl/controle_devolucao.sv
// controle_devolucao: change-return sequencer.
// Latches the credit on an accepted return request and dispenses it greedily
// (R$10, R$5, R$2, R$1), one item per ejector handshake.
// Optional feature: define DEVOLUCAO_TIMEOUT_EN to add the ack-wait timeout
// counter and the sticky ERRO state; without it the block waits forever for ack.
//
// Ejector handshake (four-phase req/ack): ejetar_req rises with ejetar_valor
// already stable; the ejector raises ejetor_ack once the item is taken; req
// falls on the next cycle and stays low until ack has been seen low; only then
// may the next req rise. ejetar_valor never changes while req is high. A low
// req outside that sequence (reset or timeout) means the ejector must abort.
module controle_devolucao
    import pkg_vending::*;
#(
    parameter int CREDITO_W      = 6,
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 devolver_dinheiro,
    input  logic [CREDITO_W-1:0] credito,
    input  logic                 ejetor_ack,
    output logic                 ejetar_req,
    output logic [1:0]           ejetar_valor,
    output logic                 Led_2,
    output logic                 Led_3,
    output logic                 concluido,
    output logic                 erro,
    output estado_t              estado_o,
    output logic [CREDITO_W-1:0] restante_o
);

    estado_t                estado_q, estado_d;
    logic [CREDITO_W-1:0]   restante_q, restante_d;
    logic [1:0]             valor_q, valor_d;
    logic                   led3_q, led3_d;
    logic                   subida;
    logic [CREDITO_W-1:0]   valor_atual;
    logic                   expirou;

    detector_borda u_detector_borda (
        .clk      (clk),
        .rst_n    (rst_n),
        .sinal_i  (devolver_dinheiro),
        .subida_o (subida)
    );

    // Amount of the item currently offered, widened to the credit width.
    assign valor_atual = CREDITO_W'(valor_item(valor_q));

`ifdef DEVOLUCAO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CICLOS + 1) > 8) ? $clog2(TIMEOUT_CICLOS + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait counter: counts cycles spent in a handshake state, restarts on any state change.
    always_comb begin
        cnt_d = '0;
        if ((estado_q == EJETA || estado_q == ESPERA_BAIXO) && estado_d == estado_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expirou = (estado_q == EJETA || estado_q == ESPERA_BAIXO) &&
                     (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CICLOS == 0);
    assign expirou        = 1'b0;
`endif

    // Next state and remaining amount.
    always_comb begin
        estado_d   = estado_q;
        restante_d = restante_q;
        case (estado_q)
            OCIOSO: begin
                if (subida) begin
                    restante_d = credito;
                    estado_d   = (credito == '0) ? CONCLUI : EJETA;
                end
            end
            EJETA: begin
                if (ejetor_ack) begin
                    restante_d = restante_q - valor_atual;
                    estado_d   = ESPERA_BAIXO;
                end
            end
            ESPERA_BAIXO: begin
                if (!ejetor_ack) begin
                    estado_d = (restante_q == '0) ? CONCLUI : EJETA;
                end
            end
            CONCLUI: begin
                estado_d = OCIOSO;
            end
`ifdef DEVOLUCAO_TIMEOUT_EN
            ERRO: begin
                estado_d = ERRO;
            end
`endif
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        // A handshake that made no progress within the limit is abandoned.
        if (expirou && estado_d == estado_q) begin
            estado_d = ERRO;
        end
    end

    // Greedy item choice from the amount that will be left next cycle.
    always_comb begin
        if (restante_d >= CREDITO_W'(VALOR_R10)) begin
            valor_d = ITEM_R10;
        end else if (restante_d >= CREDITO_W'(VALOR_R5)) begin
            valor_d = ITEM_R5;
        end else if (restante_d >= CREDITO_W'(VALOR_R2)) begin
            valor_d = ITEM_R2;
        end else begin
            valor_d = ITEM_R1;
        end
    end

    // One-cycle acknowledge pulse, raised when an item is accepted.
    always_comb begin
        led3_d = (estado_q == EJETA) && ejetor_ack;
    end

    // State, remaining amount, item code and acknowledge pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            restante_q <= '0;
            valor_q    <= ITEM_R1;
            led3_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            restante_q <= restante_d;
            valor_q    <= valor_d;
            led3_q     <= led3_d;
        end
    end

    assign ejetar_req   = (estado_q == EJETA);
    assign ejetar_valor = valor_q;
    assign Led_2        = (estado_q != OCIOSO);
    assign Led_3        = led3_q;
    assign concluido    = (estado_q == CONCLUI);
`ifdef DEVOLUCAO_TIMEOUT_EN
    assign erro         = (estado_q == ERRO);
`else
    assign erro         = 1'b0;
`endif
    assign estado_o     = estado_q;
    assign restante_o   = restante_q;

endmodule

// File: tb/tb_controle_devolucao.sv
// tb_controle_devolucao: directed bench for the change-return sequencer.
// Build with DEVOLUCAO_TIMEOUT_EN defined to exercise the ack timeout path.
module tb_controle_devolucao;
    import pkg_vending::*;

`ifdef DEVOLUCAO_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 255;
`endif

    logic       clk;
    logic       rst_n;
    logic       devolver_dinheiro;
    logic [5:0] credito;
    logic       ejetor_ack;
    logic       ejetar_req;
    logic [1:0] ejetar_valor;
    logic       Led_2;
    logic       Led_3;
    logic       concluido;
    logic       erro;
    estado_t    estado_o;
    logic [5:0] restante_o;

    logic [1:0] exp_q[$];
    int n_checks;
    int n_fail;

    controle_devolucao #(
        .CREDITO_W      (6),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .devolver_dinheiro (devolver_dinheiro),
        .credito           (credito),
        .ejetor_ack        (ejetor_ack),
        .ejetar_req        (ejetar_req),
        .ejetar_valor      (ejetar_valor),
        .Led_2             (Led_2),
        .Led_3             (Led_3),
        .concluido         (concluido),
        .erro              (erro),
        .estado_o          (estado_o),
        .restante_o        (restante_o)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aplica_reset();
        rst_n = 1'b0;
        devolver_dinheiro = 1'b0;
        ejetor_ack = 1'b0;
        credito = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Ejector side of one item: req is expected high now.
    task automatic atende(input int atraso, input int hold);
        logic [1:0] v;
        logic [5:0] rest;
        if (exp_q.size() == 0) begin
            check_eq("item_extra", ejetar_req, 0);
            step();
            return;
        end
        v = ejetar_valor;
        check_eq("valor_item", v, exp_q.pop_front());
        repeat (atraso) begin
            step();
            check_eq("req_aguarda", ejetar_req, 1);
            check_eq("valor_estavel", ejetar_valor, v);
        end
        ejetor_ack = 1'b1;
        step();
        check_eq("req_apos_ack", ejetar_req, 0);
        check_eq("led3_pulso", Led_3, 1);
        rest = restante_o;
        repeat (hold) begin
            step();
            check_eq("req_ack_alto", ejetar_req, 0);
            check_eq("led3_unico", Led_3, 0);
            check_eq("restante_fixo", restante_o, rest);
        end
        ejetor_ack = 1'b0;
        step();
    endtask

    // Full return: request, serve every item, check completion and no retrigger.
    task automatic roda(input logic [5:0] cred, input int atraso, input int hold, input bit extra);
        int guarda;
        credito = cred;
        devolver_dinheiro = 1'b1;
        step();
        check_eq("led2_ativo", Led_2, 1);
        if (extra) begin
            devolver_dinheiro = 1'b0;
            step();
            devolver_dinheiro = 1'b1;
            step();
            check_eq("estado_ignora_subida", estado_o, EJETA);
        end
        guarda = 0;
        while (concluido !== 1'b1 && guarda < 20) begin
            check_eq("req_item", ejetar_req, 1);
            atende(atraso, hold);
            guarda++;
        end
        check_eq("concluido", concluido, 1);
        check_eq("req_concluido", ejetar_req, 0);
        check_eq("restante_fim", restante_o, 0);
        check_eq("fila_vazia", exp_q.size(), 0);
        step();
        check_eq("concluido_pulso", concluido, 0);
        check_eq("led2_fim", Led_2, 0);
        repeat (3) begin
            step();
            check_eq("sem_redisparo_req", ejetar_req, 0);
            check_eq("sem_redisparo_led2", Led_2, 0);
        end
        devolver_dinheiro = 1'b0;
        step();
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        devolver_dinheiro = 1'b0;
        ejetor_ack = 1'b0;
        credito = '0;
        #1;
        check_eq("rst_req", ejetar_req, 0);
        check_eq("rst_valor", ejetar_valor, 0);
        check_eq("rst_led2", Led_2, 0);
        check_eq("rst_led3", Led_3, 0);
        check_eq("rst_concluido", concluido, 0);
        check_eq("rst_erro", erro, 0);
        check_eq("rst_estado", estado_o, OCIOSO);
        check_eq("rst_restante", restante_o, 0);
        aplica_reset();

        // R$18 = 10 + 5 + 2 + 1, ack one cycle after req.
        exp_q.push_back(ITEM_R10);
        exp_q.push_back(ITEM_R5);
        exp_q.push_back(ITEM_R2);
        exp_q.push_back(ITEM_R1);
        roda(6'd18, 1, 0, 1'b0);

        // Zero credit: straight to completion.
        roda(6'd0, 0, 0, 1'b0);

        // R$7 = 5 + 2 with a second request edge during the first item.
        exp_q.push_back(ITEM_R5);
        exp_q.push_back(ITEM_R2);
        roda(6'd7, 0, 0, 1'b1);

        // R$13 = 10 + 2 + 1 with ack held high for five cycles.
        exp_q.push_back(ITEM_R10);
        exp_q.push_back(ITEM_R2);
        exp_q.push_back(ITEM_R1);
        roda(6'd13, 0, 4, 1'b0);

        // Reset while the second item of R$25 is being requested.
        exp_q.push_back(ITEM_R10);
        credito = 6'd25;
        devolver_dinheiro = 1'b1;
        step();
        check_eq("r25_req", ejetar_req, 1);
        atende(1, 0);
        check_eq("r25_req2", ejetar_req, 1);
        check_eq("r25_valor2", ejetar_valor, ITEM_R10);
        check_eq("r25_restante", restante_o, 15);
        devolver_dinheiro = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_req", ejetar_req, 0);
        check_eq("rst_async_led2", Led_2, 0);
        check_eq("rst_async_led3", Led_3, 0);
        check_eq("rst_async_concl", concluido, 0);
        check_eq("rst_async_valor", ejetar_valor, 0);
        check_eq("rst_async_rest", restante_o, 0);
        step();
        rst_n = 1'b1;
        step();
        exp_q.delete();
        exp_q.push_back(ITEM_R5);
        exp_q.push_back(ITEM_R1);
        roda(6'd6, 1, 0, 1'b0);

        // Ack never arrives.
        aplica_reset();
        credito = 6'd3;
        devolver_dinheiro = 1'b1;
        step();
        check_eq("to_req_inicio", ejetar_req, 1);
`ifdef DEVOLUCAO_TIMEOUT_EN
        for (int i = 1; i < 20; i++) begin
            step();
            check_eq("to_req_espera", ejetar_req, 1);
            check_eq("to_erro_cedo", erro, 0);
        end
        step();
        check_eq("to_erro", erro, 1);
        check_eq("to_req_baixo", ejetar_req, 0);
        check_eq("to_led2", Led_2, 1);
        devolver_dinheiro = 1'b0;
        repeat (10) step();
        check_eq("to_erro_retido", erro, 1);
        check_eq("to_estado", estado_o, ERRO);
        aplica_reset();
        check_eq("to_erro_limpo", erro, 0);
`else
        repeat (30) step();
        check_eq("sem_to_req", ejetar_req, 1);
        check_eq("sem_to_erro", erro, 0);
        aplica_reset();
        check_eq("sem_to_req_rst", ejetar_req, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
